// File: rtl/instr_decode_pkg.sv
// Shared types and constants for the RV32I decode stage: formats, opcodes,
// the decoded-op record handed to execute and the load writeback record.
package instr_decode_pkg;

   localparam int cXLEN     = 32;
   localparam int cRegCnt   = 32;
   localparam int cRegAddrW = $clog2(cRegCnt);

   // RV32I major opcodes
   localparam logic [6:0] cOpLoad    = 7'h03;
   localparam logic [6:0] cOpMiscMem = 7'h0F;
   localparam logic [6:0] cOpImm     = 7'h13;
   localparam logic [6:0] cOpAuipc   = 7'h17;
   localparam logic [6:0] cOpStore   = 7'h23;
   localparam logic [6:0] cOpReg     = 7'h33;
   localparam logic [6:0] cOpLui     = 7'h37;
   localparam logic [6:0] cOpBranch  = 7'h63;
   localparam logic [6:0] cOpJalr    = 7'h67;
   localparam logic [6:0] cOpJal     = 7'h6F;
   localparam logic [6:0] cOpSystem  = 7'h73;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } tInstrFmt;

   typedef struct packed {
      logic                 dv;
      logic [cRegAddrW-1:0] addr;
      logic [cXLEN-1:0]     data;
   } tRegOp;

   typedef struct packed {
      logic                 valid;
      logic [cXLEN-1:0]     pc;
      logic [6:0]           opcode;
      logic [cRegAddrW-1:0] rd;
      logic [cRegAddrW-1:0] rs1;
      logic [cRegAddrW-1:0] rs2;
      logic [2:0]           f3;
      logic [6:0]           f7;
      logic [cXLEN-1:0]     imm;
      logic                 isLoad;
      logic                 isStore;
      logic                 isBranch;
      logic                 illegal;
   } tDecOp;

   // Map a major opcode onto its encoding format; anything outside RV32I is BAD.
   function automatic tInstrFmt fmt_of(input logic [6:0] opcode);
      tInstrFmt fmt;
      case (opcode)
         cOpReg:                                   fmt = FMT_R;
         cOpLoad, cOpImm, cOpJalr, cOpMiscMem,
         cOpSystem:                                fmt = FMT_I;
         cOpStore:                                 fmt = FMT_S;
         cOpBranch:                                fmt = FMT_B;
         cOpLui, cOpAuipc:                         fmt = FMT_U;
         cOpJal:                                   fmt = FMT_J;
         default:                                  fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

   // One-hot mask selecting a single architectural register.
   function automatic logic [cRegCnt-1:0] reg_mask(input logic [cRegAddrW-1:0] addr);
      logic [cRegCnt-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Bus between fetch/writeback and the decode stage. The fetch side (master)
// supplies the instruction, PC, load writeback and flush; the decode side
// (slave) returns the registered decoded op and the fetch hold request.
interface instr_decode_if;
   import instr_decode_pkg::*;

   logic [cXLEN-1:0] iInstr;
   logic [cXLEN-1:0] iCurPc;
   logic             iInstrValid;
   tRegOp            iRegOp;
   logic             iFlush;
   tDecOp            oDecOp;
   logic             oFetchNoOp;

   modport master (
      output iInstr, iCurPc, iInstrValid, iRegOp, iFlush,
      input  oDecOp, oFetchNoOp
   );

   modport slave (
      input  iInstr, iCurPc, iInstrValid, iRegOp, iFlush,
      output oDecOp, oFetchNoOp
   );

endinterface

// File: rtl/instr_decode_imm_gen.sv
// Combinational immediate generator: reassembles and sign-extends the
// immediate of an RV32I instruction according to its encoding format.
module instr_decode_imm_gen
   import instr_decode_pkg::*;
(
   input  logic [cXLEN-1:0] instr,
   input  tInstrFmt         fmt,
   output logic [cXLEN-1:0] imm
);

   // The opcode bits never contribute to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^instr[6:0];

   // Pick the immediate layout for the format; R and BAD carry no immediate.
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = {{(cXLEN-12){instr[31]}}, instr[31:20]};
         FMT_S:   imm = {{(cXLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{(cXLEN-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'b0};
         FMT_J:   imm = {{(cXLEN-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage. Decodes either the held instruction (after a load-use
// stall) or the freshly fetched one, registers the result for execute, keeps
// a scoreboard of outstanding loads and holds fetch while a source register
// is still waiting for its load data.
// Optional build macro: DECODE_PERF_EN adds stall and issue cycle counters.
module instr_decode
   import instr_decode_pkg::*;
(
   input  logic          iClk,
   input  logic          iRst,
   instr_decode_if.slave bus
`ifdef DECODE_PERF_EN
   ,
   output logic [31:0]   oStallCnt,
   output logic [31:0]   oIssueCnt
`endif
);

   logic               hold_full_q,  hold_full_d;
   logic [cXLEN-1:0]   hold_instr_q, hold_instr_d;
   logic [cXLEN-1:0]   hold_pc_q,    hold_pc_d;
   logic [cRegCnt-1:0] sb_q,         sb_d;
   tDecOp              dec_op_q,     dec_op_d;

   logic [cXLEN-1:0]   src_instr;
   logic [cXLEN-1:0]   src_pc;
   logic               src_valid;
   tInstrFmt           fmt;
   logic [cXLEN-1:0]   imm;
   tDecOp              decoded;
   logic               rs1_used;
   logic               rs2_used;
   logic [cRegCnt-1:0] sb_cleared;
   logic               hazard;
   logic               issue;
   logic               fetch_no_op;

   // Writeback data is consumed by the register file, not by decode.
   logic unused_regop_data;
   assign unused_regop_data = ^bus.iRegOp.data;

   // A stalled instruction takes precedence over whatever fetch presents.
   always_comb begin
      if (hold_full_q) begin
         src_instr = hold_instr_q;
         src_pc    = hold_pc_q;
         src_valid = 1'b1;
      end else begin
         src_instr = bus.iInstr;
         src_pc    = bus.iCurPc;
         src_valid = bus.iInstrValid;
      end
   end

   assign fmt = fmt_of(src_instr[6:0]);

   instr_decode_imm_gen u_imm_gen (
      .instr (src_instr),
      .fmt   (fmt),
      .imm   (imm)
   );

   // Field extraction; register fields a format does not use are reported as x0.
   always_comb begin
      decoded        = '0;
      rs1_used       = 1'b0;
      rs2_used       = 1'b0;
      decoded.pc     = src_pc;
      decoded.opcode = src_instr[6:0];
      decoded.f3     = src_instr[14:12];
      decoded.f7     = src_instr[31:25];
      decoded.imm    = imm;
      case (fmt)
         FMT_R: begin
            decoded.rd  = src_instr[11:7];
            decoded.rs1 = src_instr[19:15];
            decoded.rs2 = src_instr[24:20];
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
         end
         FMT_I: begin
            decoded.rd  = src_instr[11:7];
            decoded.rs1 = src_instr[19:15];
            rs1_used    = 1'b1;
         end
         FMT_S, FMT_B: begin
            decoded.rs1 = src_instr[19:15];
            decoded.rs2 = src_instr[24:20];
            rs1_used    = 1'b1;
            rs2_used    = 1'b1;
         end
         FMT_U, FMT_J: begin
            decoded.rd = src_instr[11:7];
         end
         default: begin
            decoded.illegal = 1'b1;
         end
      endcase
      decoded.isLoad   = (fmt != FMT_BAD) && (src_instr[6:0] == cOpLoad);
      decoded.isStore  = (fmt != FMT_BAD) && (src_instr[6:0] == cOpStore);
      decoded.isBranch = (fmt != FMT_BAD) && (src_instr[6:0] == cOpBranch);
   end

   // Hazard check sees the scoreboard after this cycle's writeback so a
   // returning load releases its consumer without an extra bubble.
   always_comb begin
      sb_cleared = sb_q;
      if (bus.iRegOp.dv) begin
         sb_cleared = sb_q & ~reg_mask(bus.iRegOp.addr);
      end
      hazard = src_valid &&
               ((rs1_used && sb_cleared[decoded.rs1]) ||
                (rs2_used && sb_cleared[decoded.rs2]));
      issue       = src_valid && !hazard && !bus.iFlush;
      fetch_no_op = hazard && !bus.iFlush;
   end

   // Next-state for output register, scoreboard and hold register.
   always_comb begin
      dec_op_d     = '0;
      sb_d         = sb_cleared;
      hold_full_d  = 1'b0;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if (issue) begin
         dec_op_d       = decoded;
         dec_op_d.valid = 1'b1;
         if (decoded.isLoad && (decoded.rd != '0)) begin
            sb_d = sb_d | reg_mask(decoded.rd);
         end
      end
      if (hazard && !bus.iFlush) begin
         hold_full_d  = 1'b1;
         hold_instr_d = src_instr;
         hold_pc_d    = src_pc;
      end
      sb_d[0] = 1'b0;
   end

   // Pipeline state registers.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         hold_full_q  <= 1'b0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         sb_q         <= '0;
         dec_op_q     <= '0;
      end else begin
         hold_full_q  <= hold_full_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         sb_q         <= sb_d;
         dec_op_q     <= dec_op_d;
      end
   end

   assign bus.oDecOp     = dec_op_q;
   assign bus.oFetchNoOp = fetch_no_op;

`ifdef DECODE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] issue_cnt_q, issue_cnt_d;

   // Counters advance on stall / valid-output cycles and freeze on a flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      issue_cnt_d = issue_cnt_q;
      if (!bus.iFlush) begin
         if (fetch_no_op) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
         if (dec_op_q.valid) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign oStallCnt = stall_cnt_q;
   assign oIssueCnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: a table of single-instruction decodes
// followed by hand-written load-use, bypass, x0, flush and reset sequences.
module tb_instr_decode;
   import instr_decode_pkg::*;

   localparam logic [31:0] ADDI_X1  = 32'h00500093;  // addi x1,x0,5
   localparam logic [31:0] LW_X2    = 32'h0000A103;  // lw   x2,0(x1)
   localparam logic [31:0] ADD_X3   = 32'h002101B3;  // add  x3,x2,x2
   localparam logic [31:0] LW_X5    = 32'h0000A283;  // lw   x5,0(x1)
   localparam logic [31:0] ADD_X6   = 32'h00528333;  // add  x6,x5,x5
   localparam logic [31:0] LW_X0    = 32'h0040A003;  // lw   x0,4(x1)
   localparam logic [31:0] ADD_X3_0 = 32'h000001B3;  // add  x3,x0,x0

   logic iClk = 1'b0;
   logic iRst = 1'b0;
   instr_decode_if bus ();

   int errors = 0;
   int checks = 0;

`ifdef DECODE_PERF_EN
   logic [31:0] oStallCnt;
   logic [31:0] oIssueCnt;
   int          expStall = 0;
`endif

   instr_decode dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .bus       (bus)
`ifdef DECODE_PERF_EN
      ,
      .oStallCnt (oStallCnt),
      .oIssueCnt (oIssueCnt)
`endif
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  flags;  // {isLoad, isStore, isBranch, illegal}
   } vec_t;

   vec_t vecs [8];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic dv, input logic [4:0] addr, input logic flush);
      bus.iInstrValid = v;
      bus.iInstr      = instr;
      bus.iCurPc      = pc;
      bus.iRegOp      = '{dv: dv, addr: addr, data: 32'h0};
      bus.iFlush      = flush;
   endtask

   task automatic tick(input bit stallExpected);
`ifdef DECODE_PERF_EN
      if (stallExpected) expStall++;
`else
      if (stallExpected) begin end
`endif
      @(posedge iClk);
      @(negedge iClk);
   endtask

   function automatic logic [31:0] flagsOf();
      return {28'h0, bus.oDecOp.isLoad, bus.oDecOp.isStore, bus.oDecOp.isBranch, bus.oDecOp.illegal};
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL timeout: bench did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0] = '{ADDI_X1,      32'h0,  7'h13, 5'd1, 5'd0, 5'd0, 32'h00000005, 4'b0000};
      vecs[1] = '{ADD_X3,       32'h4,  7'h33, 5'd3, 5'd2, 5'd2, 32'h00000000, 4'b0000};
      vecs[2] = '{32'h0020A423, 32'h8,  7'h23, 5'd0, 5'd1, 5'd2, 32'h00000008, 4'b0100};
      vecs[3] = '{32'hFE000CE3, 32'hC,  7'h63, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 4'b0010};
      vecs[4] = '{32'hABCDE237, 32'h10, 7'h37, 5'd4, 5'd0, 5'd0, 32'hABCDE000, 4'b0000};
      vecs[5] = '{32'hFFF08393, 32'h14, 7'h13, 5'd7, 5'd1, 5'd0, 32'hFFFFFFFF, 4'b0000};
      vecs[6] = '{32'h010000EF, 32'h18, 7'h6F, 5'd1, 5'd0, 5'd0, 32'h00000010, 4'b0000};
      vecs[7] = '{32'h0000007F, 32'h1C, 7'h7F, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'b0001};

      // Reset state
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      iRst = 1'b0;
      repeat (2) @(negedge iClk);
      checkOutput("reset.valid", 32'(bus.oDecOp.valid), 32'd0);
      checkOutput("reset.decop_nonzero", 32'(|bus.oDecOp), 32'd0);
      checkOutput("reset.noop", 32'(bus.oFetchNoOp), 32'd0);
      iRst = 1'b1;
      @(negedge iClk);

      // Single-instruction decodes, one cycle latency each
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b0, 5'd0, 1'b0);
         tick(1'b0);
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
         checkOutput($sformatf("v%0d.valid", i), 32'(bus.oDecOp.valid), 32'd1);
         checkOutput($sformatf("v%0d.pc", i), bus.oDecOp.pc, vecs[i].pc);
         checkOutput($sformatf("v%0d.opcode", i), 32'(bus.oDecOp.opcode), 32'(vecs[i].op));
         checkOutput($sformatf("v%0d.rd", i), 32'(bus.oDecOp.rd), 32'(vecs[i].rd));
         checkOutput($sformatf("v%0d.rs1", i), 32'(bus.oDecOp.rs1), 32'(vecs[i].rs1));
         checkOutput($sformatf("v%0d.rs2", i), 32'(bus.oDecOp.rs2), 32'(vecs[i].rs2));
         checkOutput($sformatf("v%0d.imm", i), bus.oDecOp.imm, vecs[i].imm);
         checkOutput($sformatf("v%0d.flags", i), flagsOf(), 32'(vecs[i].flags));
      end
      tick(1'b0);
      checkOutput("idle.valid", 32'(bus.oDecOp.valid), 32'd0);

      // Load-use hazard: add x3,x2,x2 waits for x2's writeback
      applyStimulus(1'b1, LW_X2, 32'h100, 1'b0, 5'd0, 1'b0);
      tick(1'b0);
      checkOutput("lu.lw_valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("lu.lw_flags", flagsOf(), 32'h8);
      applyStimulus(1'b1, ADD_X3, 32'h104, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("lu.noop_raise", 32'(bus.oFetchNoOp), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1);
         applyStimulus(1'b1, ADDI_X1, 32'h108, 1'b0, 5'd0, 1'b0);
         #1;
         checkOutput($sformatf("lu.bubble%0d", k), 32'(bus.oDecOp.valid), 32'd0);
         checkOutput($sformatf("lu.noop%0d", k), 32'(bus.oFetchNoOp), 32'd1);
      end
      applyStimulus(1'b1, ADDI_X1, 32'h108, 1'b1, 5'd2, 1'b0);
      #1;
      checkOutput("lu.release_noop", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("lu.add_valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("lu.add_pc", bus.oDecOp.pc, 32'h104);
      checkOutput("lu.add_rd", 32'(bus.oDecOp.rd), 32'd3);
      applyStimulus(1'b1, ADD_X3, 32'h10C, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("lu.bit2_clear", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("lu.add2_valid", 32'(bus.oDecOp.valid), 32'd1);
`ifdef DECODE_PERF_EN
      checkOutput("perf.stall_lu", oStallCnt, 32'(expStall));
`endif

      // Load issuing while the same register is written back: set wins
      applyStimulus(1'b1, LW_X5, 32'h200, 1'b1, 5'd5, 1'b0);
      tick(1'b0);
      applyStimulus(1'b1, ADD_X6, 32'h204, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("setwins.stall", 32'(bus.oFetchNoOp), 32'd1);
      // Same-cycle writeback bypasses the stall
      applyStimulus(1'b1, ADD_X6, 32'h204, 1'b1, 5'd5, 1'b0);
      #1;
      checkOutput("bypass.noop", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("bypass.valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("bypass.rd", 32'(bus.oDecOp.rd), 32'd6);

      // Load to x0 never marks the scoreboard
      applyStimulus(1'b1, LW_X0, 32'h300, 1'b0, 5'd0, 1'b0);
      tick(1'b0);
      checkOutput("x0.lw_valid", 32'(bus.oDecOp.valid), 32'd1);
      applyStimulus(1'b1, ADD_X3_0, 32'h304, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("x0.noop", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("x0.add_valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("x0.add_pc", bus.oDecOp.pc, 32'h304);

      // Flush during a stall empties the hold register but keeps the scoreboard
      applyStimulus(1'b1, LW_X2, 32'h400, 1'b0, 5'd0, 1'b0);
      tick(1'b0);
      applyStimulus(1'b1, ADD_X3, 32'h404, 1'b0, 5'd0, 1'b0);
      tick(1'b1);
      checkOutput("flush.pre_bubble", 32'(bus.oDecOp.valid), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      #1;
      checkOutput("flush.noop_comb", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("flush.valid", 32'(bus.oDecOp.valid), 32'd0);
      checkOutput("flush.hold_empty", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      checkOutput("flush.no_reissue", 32'(bus.oDecOp.valid), 32'd0);
      applyStimulus(1'b1, ADD_X3, 32'h408, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("flush.sb_kept", 32'(bus.oFetchNoOp), 32'd1);
      tick(1'b1);
      applyStimulus(1'b1, ADD_X3, 32'h408, 1'b1, 5'd2, 1'b0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("flush.add_valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("flush.add_pc", bus.oDecOp.pc, 32'h408);

      // Flush kills a clean instruction too
      applyStimulus(1'b1, ADDI_X1, 32'h500, 1'b0, 5'd0, 1'b1);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("flush.kill_valid", 32'(bus.oDecOp.valid), 32'd0);

      // Flush together with a hazard: no capture
      applyStimulus(1'b1, LW_X2, 32'h600, 1'b0, 5'd0, 1'b0);
      tick(1'b0);
      applyStimulus(1'b1, ADD_X3, 32'h604, 1'b0, 5'd0, 1'b1);
      #1;
      checkOutput("flushhaz.noop", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("flushhaz.no_capture", 32'(bus.oFetchNoOp), 32'd0);
      checkOutput("flushhaz.valid", 32'(bus.oDecOp.valid), 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
`ifdef DECODE_PERF_EN
      checkOutput("perf.stall_total", oStallCnt, 32'(expStall));
`endif

      // Reset in the middle of a stall
      applyStimulus(1'b1, LW_X2, 32'h700, 1'b0, 5'd0, 1'b0);
      tick(1'b0);
      applyStimulus(1'b1, ADD_X3, 32'h704, 1'b0, 5'd0, 1'b0);
      tick(1'b1);
      iRst = 1'b0;
      #1;
      checkOutput("rststall.valid", 32'(bus.oDecOp.valid), 32'd0);
      checkOutput("rststall.noop", 32'(bus.oFetchNoOp), 32'd0);
`ifdef DECODE_PERF_EN
      checkOutput("rststall.stallcnt", oStallCnt, 32'd0);
      checkOutput("rststall.issuecnt", oIssueCnt, 32'd0);
`endif
      @(negedge iClk);
      iRst = 1'b1;
      #1;
      checkOutput("rststall.after_noop", 32'(bus.oFetchNoOp), 32'd0);
      tick(1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("rststall.add_valid", 32'(bus.oDecOp.valid), 32'd1);
      checkOutput("rststall.add_pc", bus.oDecOp.pc, 32'h704);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
